change_dispenser: RTL

- Downstream actuator stage for the vending controller FSM: consumes its registered purchase flag and cash_return code (00 none, 01 5tk, 10 10tk, 11 15tk).
- Drives the product-vend motor and a 5tk coin hopper, one coin at a time, with sensor handshakes and timeouts.
- Buffers one pending transaction.
- Raises sticky fault and overflow flags for the maintenance interface.

---
 rtl/change_dispenser.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Vend-motor / coin-hopper actuator stage behind the vending controller FSM.
// Detects purchase/change events, buffers one pending job, drives motor and hopper with timeouts.
module change_dispenser #(
  parameter int PULSE_W = 4,
  parameter int TIMEOUT = 1000,
  parameter int TMR_W   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       purchase,
  input  logic [1:0] cash_return,
  input  logic       vend_done,
  input  logic       coin_ack,
  output logic       vend_motor,
  output logic       coin_release,
  output logic       busy,
  output logic       fault,
  output logic       overflow,
  output logic [7:0] coins_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_VEND    = 3'd1,
    S_C_PULSE = 3'd2,
    S_C_WAIT  = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMO_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] PULSE_LAST = TMR_W'(PULSE_W - 1);

  state_t           state_q, state_nx;
  logic [2:0]       last_q;
  logic             pend_vld_q, pend_vld_nx;
  logic [2:0]       pend_q, pend_nx;
  logic [TMR_W-1:0] tmr_q, tmr_nx;
  logic [1:0]       cnt_q, cnt_nx;
  logic [2:0]       s;
  logic [2:0]       start_s;
  logic             evt, start, ovf_set, coin_inc;

  function automatic logic [7:0] wrap_inc(input logic [7:0] v);
    return v + 8'd1;
  endfunction

  assign s   = {purchase, cash_return};
  assign evt = (s != 3'b000) && (s != last_q);

  // Event routing: start now, park in the single pending slot, or drop.
  always_comb begin
    pend_vld_nx = pend_vld_q;
    pend_nx     = pend_q;
    start       = 1'b0;
    start_s     = s;
    ovf_set     = 1'b0;
    if (state_q == S_IDLE && pend_vld_q) begin
      start       = 1'b1;
      start_s     = pend_q;
      pend_vld_nx = 1'b0;
      if (evt) begin
        pend_vld_nx = 1'b1;
        pend_nx     = s;
      end
    end else if (evt) begin
      if (state_q == S_IDLE) begin
        start = 1'b1;
      end else if (!pend_vld_q) begin
        pend_vld_nx = 1'b1;
        pend_nx     = s;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state_q;
    tmr_nx   = tmr_q + TMR_ONE;
    cnt_nx   = cnt_q;
    coin_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_nx = '0;
        if (start) begin
          cnt_nx   = start_s[1:0];
          state_nx = start_s[2] ? S_VEND : S_C_PULSE;
        end
      end
      S_VEND: begin
        // The sensor takes priority over a timeout landing in the same cycle.
        if (vend_done) begin
          tmr_nx   = '0;
          state_nx = (cnt_q != 2'd0) ? S_C_PULSE : S_IDLE;
        end else if (tmr_q == TMO_LAST) begin
          tmr_nx   = '0;
          state_nx = S_FAULT;
        end
      end
      S_C_PULSE: begin
        if (tmr_q == PULSE_LAST) begin
          tmr_nx   = '0;
          state_nx = S_C_WAIT;
        end
      end
      S_C_WAIT: begin
        if (coin_ack) begin
          coin_inc = 1'b1;
          cnt_nx   = cnt_q - 2'd1;
          tmr_nx   = '0;
          state_nx = (cnt_q == 2'd1) ? S_IDLE : S_C_PULSE;
        end else if (tmr_q == TMO_LAST) begin
          tmr_nx   = '0;
          state_nx = S_FAULT;
        end
      end
      S_FAULT: begin
        tmr_nx = '0;
      end
      default: begin
        tmr_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  // Register stage: state, bookkeeping, and outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_q       <= 3'b000;
      pend_vld_q   <= 1'b0;
      pend_q       <= 3'b000;
      tmr_q        <= '0;
      cnt_q        <= 2'd0;
      coins_out    <= 8'd0;
      overflow     <= 1'b0;
      vend_motor   <= 1'b0;
      coin_release <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state_q      <= state_nx;
      last_q       <= s;
      pend_vld_q   <= pend_vld_nx;
      pend_q       <= pend_nx;
      tmr_q        <= tmr_nx;
      cnt_q        <= cnt_nx;
      coins_out    <= coin_inc ? wrap_inc(coins_out) : coins_out;
      overflow     <= overflow | ovf_set;
      vend_motor   <= (state_nx == S_VEND);
      coin_release <= (state_nx == S_C_PULSE);
      busy         <= (state_nx != S_IDLE) | pend_vld_nx;
      fault        <= (state_nx == S_FAULT);
    end
  end

endmodule
